// File: rtl/ram_8_arbiter_if.sv
// ram_8_arbiter_if: bundle of the two requester handshakes and the ram_8 pins.
//   slave  - arbiter side: takes requests and ram_out, drives acks, read data
//            and the ram_8 in/address/load pins.
//   master - environment side: the clients A/B and the ram_8 instance.
// Signals per requester X in {a, b}:
//   x_req, x_we, x_address, x_wdata   request and command (master -> slave)
//   x_ack, x_rdata                    completion pulse and read data (slave -> master)
// Memory side:
//   ram_in, ram_address, ram_load     slave -> ram_8
//   ram_out                           ram_8 -> slave
interface ram_8_arbiter_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
);
    logic                  a_req;
    logic                  a_we;
    logic [ADDR_WIDTH-1:0] a_address;
    logic [DATA_WIDTH-1:0] a_wdata;
    logic                  a_ack;
    logic [DATA_WIDTH-1:0] a_rdata;

    logic                  b_req;
    logic                  b_we;
    logic [ADDR_WIDTH-1:0] b_address;
    logic [DATA_WIDTH-1:0] b_wdata;
    logic                  b_ack;
    logic [DATA_WIDTH-1:0] b_rdata;

    logic [DATA_WIDTH-1:0] ram_in;
    logic [ADDR_WIDTH-1:0] ram_address;
    logic                  ram_load;
    logic [DATA_WIDTH-1:0] ram_out;

    modport slave (
        input  a_req, a_we, a_address, a_wdata,
        output a_ack, a_rdata,
        input  b_req, b_we, b_address, b_wdata,
        output b_ack, b_rdata,
        output ram_in, ram_address, ram_load,
        input  ram_out
    );

    modport master (
        output a_req, a_we, a_address, a_wdata,
        input  a_ack, a_rdata,
        output b_req, b_we, b_address, b_wdata,
        input  b_ack, b_rdata,
        input  ram_in, ram_address, ram_load,
        output ram_out
    );
endinterface

// File: rtl/ram_8_arbiter.sv
// ram_8_arbiter: shares one ram_8 between requesters A and B. Each request is
// a single-word read or write with a req/ack handshake; the winner's command
// is latched at grant, drives the ram_8 for exactly one access cycle, and the
// owner gets a one-cycle ack (plus read data for reads) in the following cycle.
//
// Ports:
//   i_clock  system clock, rising edge
//   i_reset  synchronous, active-high reset
//   bus      ram_8_arbiter_if.slave: A/B handshakes and the ram_8 pins
//
// Build option:
//   RAM8_ARB_RR_EN  defined   -> round-robin on a tie (port that did not own
//                                the previous grant wins)
//                   undefined -> fixed priority, A wins every tie
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | sample a_req/b_req, pick winner, latch its command
// ACCESS | drive ram_8 with latched command; write commits / read captured
// DONE   | one-cycle ack to the owner
module ram_8_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic           i_clock,
    input  logic           i_reset,
    ram_8_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    localparam logic OWNER_A = 1'b0;
    localparam logic OWNER_B = 1'b1;

    state_t                r_state;
    state_t                w_state_next;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_address;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_owner;
    logic [DATA_WIDTH-1:0] r_a_rdata;
    logic [DATA_WIDTH-1:0] r_b_rdata;
    logic                  w_grant;
    logic                  w_grant_b;
    logic                  w_done;
`ifdef RAM8_ARB_RR_EN
    logic                  r_last_owner;
`endif

    always_comb begin
        w_state_next = r_state;
        w_grant      = 1'b0;
        w_grant_b    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.a_req || bus.b_req) begin
                    w_grant = 1'b1;
`ifdef RAM8_ARB_RR_EN
                    // On a tie the port that did not win last time goes next.
                    if (bus.a_req && bus.b_req)
                        w_grant_b = (r_last_owner == OWNER_A);
                    else
                        w_grant_b = bus.b_req;
`else
                    w_grant_b = !bus.a_req;
`endif
                    w_state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_we         <= 1'b0;
            r_address    <= '0;
            r_wdata      <= '0;
            r_owner      <= OWNER_A;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
`ifdef RAM8_ARB_RR_EN
            r_last_owner <= OWNER_B;
`endif
        end else begin
            r_state <= w_state_next;
            if (w_grant) begin
                r_owner   <= w_grant_b;
                r_we      <= w_grant_b ? bus.b_we      : bus.a_we;
                r_address <= w_grant_b ? bus.b_address : bus.a_address;
                r_wdata   <= w_grant_b ? bus.b_wdata   : bus.a_wdata;
`ifdef RAM8_ARB_RR_EN
                r_last_owner <= w_grant_b;
`endif
            end
            // ram_out is a combinational read of r_address, valid in ACCESS.
            if (r_state == ST_ACCESS && !r_we) begin
                if (r_owner == OWNER_B)
                    r_b_rdata <= bus.ram_out;
                else
                    r_a_rdata <= bus.ram_out;
            end
        end
    end

    // Gating with i_reset keeps a reset landing in ACCESS from committing a write.
    assign bus.ram_load    = (r_state == ST_ACCESS) && r_we && !i_reset;
    assign bus.ram_address = r_address;
    assign bus.ram_in      = r_wdata;

    assign w_done      = (r_state == ST_DONE) && !i_reset;
    assign bus.a_ack   = w_done && (r_owner == OWNER_A);
    assign bus.b_ack   = w_done && (r_owner == OWNER_B);
    assign bus.a_rdata = r_a_rdata;
    assign bus.b_rdata = r_b_rdata;
endmodule

// File: tb/tb_ram_8_arbiter.sv
// Bench for ram_8_arbiter: drivers push each issued command into a per-port
// queue; a negedge monitor follows a transaction-level schedule (grant in the
// first idle cycle with a request, ack two cycles later, idle again the cycle
// after) and a reference memory, and compares acks, read data and ram pins.
module tb_ram_8_arbiter;
    localparam int DW = 16;
    localparam int AW = 3;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
    } cmd_t;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    ram_8_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();
    ram_8_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .i_clock (clock),
        .i_reset (reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // ram_8 stand-in: registered write, combinational read.
    logic [DW-1:0] ram [8] = '{default: '0};
    always @(posedge clock) if (bus.ram_load) ram[bus.ram_address] <= bus.ram_in;
    assign bus.ram_out = ram[bus.ram_address];

    cmd_t q_a[$];
    cmd_t q_b[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- reference model / monitor ----------------
    logic [DW-1:0] ref_mem [8] = '{default: '0};
    logic [DW-1:0] ref_rd_a = '0;
    logic [DW-1:0] ref_rd_b = '0;
    logic [AW-1:0] m_lat_addr = '0;
    logic [DW-1:0] m_lat_wdata = '0;
    bit   m_pend = 0;
    bit   m_pend_port = 0;
    int   m_pend_cycle = -1;
    int   m_acc_cycle = -1;
    bit   m_acc_we = 0;
    int   m_idle_at = 0;
    bit   m_last_owner = 1;
    bit   m_ack_now;
    bit   m_win;
    cmd_t m_cmd;

    always @(negedge clock) begin
        if (reset) begin
            chk("load_in_reset", bus.ram_load, 0);
            chk("a_ack_in_reset", bus.a_ack, 0);
            chk("b_ack_in_reset", bus.b_ack, 0);
            q_a.delete();
            q_b.delete();
            m_pend = 0;
            m_acc_cycle = -1;
            m_lat_addr = '0;
            m_lat_wdata = '0;
            ref_rd_a = '0;
            ref_rd_b = '0;
            m_last_owner = 1;
            m_idle_at = cyc + 1;
        end else begin
            m_ack_now = m_pend && (m_pend_cycle == cyc);
            chk("a_ack", bus.a_ack, m_ack_now && !m_pend_port);
            chk("b_ack", bus.b_ack, m_ack_now && m_pend_port);
            if (m_ack_now) begin
                m_pend = 0;
                if ((m_pend_port ? q_b.size() : q_a.size()) == 0) begin
                    chk("scoreboard_empty_at_ack", 1, 0);
                end else begin
                    m_cmd = m_pend_port ? q_b.pop_front() : q_a.pop_front();
                    if (m_cmd.we)
                        ref_mem[m_cmd.addr] = m_cmd.wdata;
                    else if (m_pend_port)
                        ref_rd_b = ref_mem[m_cmd.addr];
                    else
                        ref_rd_a = ref_mem[m_cmd.addr];
                end
            end
            chk("a_rdata", bus.a_rdata, ref_rd_a);
            chk("b_rdata", bus.b_rdata, ref_rd_b);
            chk("ram_load", bus.ram_load, (m_acc_cycle == cyc) && m_acc_we);
            chk("ram_address", bus.ram_address, m_lat_addr);
            chk("ram_in", bus.ram_in, m_lat_wdata);
            if (!m_pend && cyc >= m_idle_at && (bus.a_req || bus.b_req)) begin
`ifdef RAM8_ARB_RR_EN
                if (bus.a_req && bus.b_req) m_win = !m_last_owner;
                else                        m_win = bus.b_req;
`else
                m_win = !bus.a_req;
`endif
                if ((m_win ? q_b.size() : q_a.size()) == 0) begin
                    chk("scoreboard_empty_at_grant", 1, 0);
                end else begin
                    m_cmd = m_win ? q_b[0] : q_a[0];
                    m_lat_addr = m_cmd.addr;
                    m_lat_wdata = m_cmd.wdata;
                    m_acc_we = m_cmd.we;
                    m_acc_cycle = cyc + 1;
                    m_pend = 1;
                    m_pend_port = m_win;
                    m_pend_cycle = cyc + 2;
                    m_idle_at = cyc + 3;
                    m_last_owner = m_win;
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic drive(input bit port, input logic we, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata);
        cmd_t c;
        c.we = we;
        c.addr = addr;
        c.wdata = wdata;
        if (!port) begin
            bus.a_we = we; bus.a_address = addr; bus.a_wdata = wdata; bus.a_req = 1'b1;
            q_a.push_back(c);
        end else begin
            bus.b_we = we; bus.b_address = addr; bus.b_wdata = wdata; bus.b_req = 1'b1;
            q_b.push_back(c);
        end
    endtask

    task automatic release_req(input bit port);
        if (!port) bus.a_req = 1'b0;
        else       bus.b_req = 1'b0;
    endtask

    // Returns at posedge+1 of the idle cycle following the ack.
    task automatic wait_ack(input bit port);
        bit seen = 0;
        int n = 0;
        while (!seen && n < 1500) begin
            @(negedge clock);
            seen = port ? bus.b_ack : bus.a_ack;
            n++;
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL ack_timeout port %0d: got no ack, expected one within 1500 cycles", port);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic txn(input bit port, input logic we, input logic [AW-1:0] addr,
                       input logic [DW-1:0] wdata);
        drive(port, we, addr, wdata);
        wait_ack(port);
        release_req(port);
    endtask

    task automatic random_port(input bit port, input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            drive(port, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom));
            wait_ack(port);
            gap = $urandom_range(0, 2);
            if (gap != 0) begin
                release_req(port);
                repeat (gap) @(posedge clock);
                #1;
            end
        end
        release_req(port);
    endtask

    initial begin
        bus.a_req = 0; bus.a_we = 0; bus.a_address = '0; bus.a_wdata = '0;
        bus.b_req = 0; bus.b_we = 0; bus.b_address = '0; bus.b_wdata = '0;
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // A only: write then read back
        txn(0, 1'b1, 3'd5, 16'hBEEF);
        txn(0, 1'b0, 3'd5, 16'h0000);

        // Read data isolation
        for (int i = 0; i < 8; i++) txn(0, 1'b1, 3'(i), 16'(i));
        txn(1, 1'b0, 3'd7, 16'h0000);
        txn(0, 1'b1, 3'd7, 16'h5A5A);

        // Command inputs change after grant
        drive(0, 1'b1, 3'd4, 16'h1234);
        @(posedge clock);
        #1;
        bus.a_address = 3'd6;
        bus.a_wdata = 16'hFFFF;
        wait_ack(0);
        release_req(0);
        txn(0, 1'b0, 3'd4, 16'h0000);
        txn(1, 1'b0, 3'd6, 16'h0000);

        // Reset during ACCESS aborts the write
        txn(0, 1'b1, 3'd2, 16'h0F0F);
        drive(0, 1'b1, 3'd2, 16'hAAAA);
        @(posedge clock);
        #1;
        reset = 1'b1;
        bus.a_req = 1'b0;
        @(posedge clock);
        #1 reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        txn(0, 1'b0, 3'd2, 16'h0000);
        txn(1, 1'b0, 3'd2, 16'h0000);

        // Contention on address 3, both requests held high
        fork
            begin
                drive(0, 1'b1, 3'd3, 16'h1111); wait_ack(0);
                drive(0, 1'b1, 3'd3, 16'h1111); wait_ack(0);
                release_req(0);
            end
            begin
                drive(1, 1'b1, 3'd3, 16'h2222); wait_ack(1);
                drive(1, 1'b1, 3'd3, 16'h2222); wait_ack(1);
                release_req(1);
            end
        join
        txn(1, 1'b0, 3'd3, 16'h0000);

        // Randomized traffic on both ports
        fork
            random_port(0, 30);
            random_port(1, 30);
        join
        repeat (5) @(posedge clock);
        #1;
        chk("q_a_drained", q_a.size(), 0);
        chk("q_b_drained", q_b.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no end of test, expected finish before 100000 cycles");
        $fatal(1);
    end
endmodule
